// File: rtl/imem_banked_pkg.sv
// imem_banked_pkg: shared FSM encodings, fault causes and parity helper for the banked instruction memory
package imem_banked_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      FC_NONE     = 2'd0,
      FC_MISALIGN = 2'd1,
      FC_RANGE    = 2'd2,
      FC_PARITY   = 2'd3
   } fault_cause_t;

   localparam int LANES_MAX = 16;

   // even parity bit for one byte lane
   function automatic logic even_par(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/imem_banked_bank.sv
// imem_bank: one byte lane of the instruction memory, sync write and sync read with enables
module imem_bank #(
   parameter int DEPTH = 4096,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     re,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   // storage is never reset; read data register holds until the next enabled read
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/imem_banked.sv
// imem_banked: byte-lane-banked instruction memory with fetch port and LOAD-mode write port; optional IMEM_PARITY_EN
module imem_banked
   import imem_banked_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 4096,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   prog_mode_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [ADDR_W-1:0]      req_addr_i,
   output logic                   resp_valid_o,
   input  logic                   resp_ready_i,
   output logic [DATA_W-1:0]      resp_data_o,
   output logic                   resp_fault_o,
   input  logic                   wr_valid_i,
   output logic                   wr_ready_o,
   input  logic [ADDR_W-1:0]      wr_addr_i,
   input  logic [DATA_W-1:0]      wr_data_i,
   input  logic [DATA_W/8-1:0]    wr_be_i,
   output logic                   wr_err_o,
   output logic                   mode_load_o,
   output logic                   par_err_o
);

   localparam int LANES = DATA_W / 8;
   localparam int LB    = $clog2(LANES);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * LANES);
`ifdef IMEM_PARITY_EN
   localparam int BW = 9;
`else
   localparam int BW = 8;
`endif

   // offsets below BASE_ADDR wrap to huge values and fall out of range
   function automatic fault_cause_t addr_check(input logic [ADDR_W-1:0] off);
      return (off[LB-1:0] != '0) ? FC_MISALIGN : (off >= SPAN) ? FC_RANGE : FC_NONE;
   endfunction

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   r_off, w_off;
   fault_cause_t        rd_cause, wr_cause;
   logic                req_acc, wr_acc, rd_en, wr_ok;
   logic [IDX_W-1:0]    bank_addr;
   logic [DATA_W-1:0]   rdata;
   logic                addr_fault, rd_ok, fresh, par_bad;

   assign r_off     = req_addr_i - BASE_ADDR;
   assign w_off     = wr_addr_i - BASE_ADDR;
   assign rd_cause  = addr_check(r_off);
   assign wr_cause  = addr_check(w_off);
   assign req_acc   = req_valid_i & req_ready_o;
   assign wr_acc    = wr_valid_i & wr_ready_o;
   assign rd_en     = req_acc & (rd_cause == FC_NONE);
   assign wr_ok     = wr_acc & (wr_cause == FC_NONE);
   assign bank_addr = mode_load_o ? w_off[LB +: IDX_W] : r_off[LB +: IDX_W];

   // mode state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RUN;
      else        state <= state_nxt;
   end

   // DRAIN waits for the held response to leave before opening the write port
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   state_nxt = prog_mode_i ? ST_DRAIN : ST_RUN;
         ST_DRAIN: state_nxt = (!resp_valid_o || resp_ready_i) ? ST_LOAD : ST_DRAIN;
         ST_LOAD:  state_nxt = prog_mode_i ? ST_LOAD : ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // mode-dependent handshake outputs
   always_comb begin
      mode_load_o = (state == ST_LOAD);
      wr_ready_o  = (state == ST_LOAD);
      req_ready_o = (state == ST_RUN) && (!resp_valid_o || resp_ready_i);
   end

   // response register: captured on accept, held under back-pressure, cleared after handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_o <= 1'b0;
         addr_fault   <= 1'b0;
         rd_ok        <= 1'b0;
         fresh        <= 1'b0;
         wr_err_o     <= 1'b0;
      end else begin
         fresh    <= req_acc;
         wr_err_o <= wr_acc && (wr_cause != FC_NONE);
         if (req_acc) begin
            resp_valid_o <= 1'b1;
            addr_fault   <= (rd_cause != FC_NONE);
            rd_ok        <= (rd_cause == FC_NONE);
         end else if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
         end
      end
   end

`ifdef IMEM_PARITY_EN
   logic [LANES-1:0] lane_bad;
`endif

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [BW-1:0] wd, rd;
`ifdef IMEM_PARITY_EN
      assign wd          = {even_par(wr_data_i[8*i +: 8]), wr_data_i[8*i +: 8]};
      assign lane_bad[i] = ^rd;
`else
      assign wd = wr_data_i[8*i +: 8];
`endif
      assign rdata[8*i +: 8] = rd[7:0];
      imem_bank #(.DEPTH(DEPTH), .W(BW)) u_bank (
         .clk   (clk),
         .re    (rd_en),
         .we    (wr_ok & wr_be_i[i]),
         .addr  (bank_addr),
         .wdata (wd),
         .rdata (rd)
      );
   end

`ifdef IMEM_PARITY_EN
   assign par_bad = rd_ok & (|lane_bad);
`else
   assign par_bad = 1'b0;
`endif

   assign resp_data_o  = rd_ok ? rdata : '0;
   assign resp_fault_o = addr_fault | par_bad;
   assign par_err_o    = fresh & par_bad;

endmodule

// File: tb/tb_imem_banked.sv
// tb_imem_banked: directed scoreboard bench for imem_banked (T6 only when IMEM_PARITY_EN is defined)
module tb_imem_banked;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        prog_mode_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        resp_ready_i = 1'b1;
   logic        wr_valid_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] wr_addr_i = '0;
   logic [31:0] wr_data_i = '0;
   logic [3:0]  wr_be_i = '0;
   logic        req_ready_o, resp_valid_o, resp_fault_o, wr_ready_o, wr_err_o, mode_load_o, par_err_o;
   logic [31:0] resp_data_o;

   int          checks = 0;
   int          failures = 0;
   int          pops = 0;
   int          p0;
   logic [32:0] sb[$];

   always #5 clk = ~clk;

   imem_banked dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .prog_mode_i  (prog_mode_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_data_o  (resp_data_o),
      .resp_fault_o (resp_fault_o),
      .wr_valid_i   (wr_valid_i),
      .wr_ready_o   (wr_ready_o),
      .wr_addr_i    (wr_addr_i),
      .wr_data_i    (wr_data_i),
      .wr_be_i      (wr_be_i),
      .wr_err_o     (wr_err_o),
      .mode_load_o  (mode_load_o),
      .par_err_o    (par_err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one cycle: at the negedge retire a handshaking response against the scoreboard, then step past the posedge
   task automatic tick();
      logic [32:0] e;
      @(negedge clk);
      if (resp_valid_o && resp_ready_i) begin
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_fault", resp_fault_o, e[32]);
            chk("resp_data", resp_data_o, e[31:0]);
         end
         pops++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic f, input logic [31:0] d);
      chk("req_ready", req_ready_o, 1'b1);
      req_valid_i = 1'b1;
      req_addr_i  = a;
      sb.push_back({f, d});
      tick();
      req_valid_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic f);
      wr_valid_i = 1'b1;
      wr_addr_i  = a;
      wr_data_i  = d;
      wr_be_i    = be;
      tick();
      wr_valid_i = 1'b0;
      chk("wr_err", wr_err_o, f);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk("rst_resp_valid", resp_valid_o, 1'b0);
      chk("rst_resp_fault", resp_fault_o, 1'b0);
      chk("rst_resp_data", resp_data_o, 32'h0);
      chk("rst_wr_err", wr_err_o, 1'b0);
      chk("rst_par_err", par_err_o, 1'b0);
      chk("rst_mode_load", mode_load_o, 1'b0);
      chk("rst_req_ready", req_ready_o, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      // T1/T2/T3 loads
      prog_mode_i = 1'b1;
      tick();
      chk("drain_no_load", mode_load_o, 1'b0);
      tick();
      chk("load_mode", mode_load_o, 1'b1);
      chk("load_wr_ready", wr_ready_o, 1'b1);
      chk("load_req_ready", req_ready_o, 1'b0);
      wr(32'h0, 32'h0000_0013, 4'hF, 1'b0);
      wr(32'h4, 32'hDEAD_BEEF, 4'hF, 1'b0);
      wr(32'h8, 32'hAABB_CCDD, 4'hF, 1'b0);
      wr(32'h8, 32'h1122_3344, 4'b0101, 1'b0);
      wr(32'h4000, 32'hFFFF_FFFF, 4'hF, 1'b1);
      wr(32'h2, 32'hFFFF_FFFF, 4'hF, 1'b1);
      tick();
      chk("wr_err_pulse_end", wr_err_o, 1'b0);
      prog_mode_i = 1'b0;
      tick();
      chk("run_mode", mode_load_o, 1'b0);
      chk("run_wr_ready", wr_ready_o, 1'b0);
      wr_valid_i = 1'b1;
      wr_addr_i  = 32'h4000;
      tick();
      wr_valid_i = 1'b0;
      chk("run_wr_ignored", wr_err_o, 1'b0);
      // T1 back-to-back fetch
      p0 = pops;
      req(32'h0, 1'b0, 32'h0000_0013);
      req(32'h4, 1'b0, 32'hDEAD_BEEF);
      chk("b2b_first", 64'(pops - p0), 64'd1);
      tick();
      chk("b2b_second", 64'(pops - p0), 64'd2);
      // T2 partial write, T3 faults and untouched word 0
      req(32'h8, 1'b0, 32'hAA22_CC44);
      req(32'h2, 1'b1, 32'h0);
      req(32'h4000, 1'b1, 32'h0);
      req(32'hFFFF_FFFC, 1'b1, 32'h0);
      req(32'h0, 1'b0, 32'h0000_0013);
      tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);
`ifdef IMEM_PARITY_EN
      // T6 corrupt one stored bit and fetch it
      dut.g_lane[2].u_bank.mem[0][3] = ~dut.g_lane[2].u_bank.mem[0][3];
      req(32'h0, 1'b1, 32'h0000_0013);
      chk("par_err_pulse", par_err_o, 1'b1);
      tick();
      chk("par_err_end", par_err_o, 1'b0);
      dut.g_lane[2].u_bank.mem[0][3] = ~dut.g_lane[2].u_bank.mem[0][3];
`endif
      // T4 back-pressure while entering DRAIN
      resp_ready_i = 1'b0;
      req(32'h4, 1'b0, 32'hDEAD_BEEF);
      prog_mode_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_valid", resp_valid_o, 1'b1);
         chk("hold_data", resp_data_o, 32'hDEAD_BEEF);
         chk("hold_req_ready", req_ready_o, 1'b0);
         chk("hold_no_load", mode_load_o, 1'b0);
      end
      resp_ready_i = 1'b1;
      tick();
      chk("drain_to_load", mode_load_o, 1'b1);
      chk("drain_resp_cleared", resp_valid_o, 1'b0);
      chk("sb_drained_t4", 64'(sb.size()), 64'd0);
      // T5 async reset during LOAD with a bad write in flight
      wr_valid_i = 1'b1;
      wr_addr_i  = 32'h4000;
      @(posedge clk);
      #1;
      chk("t5_wr_err_before", wr_err_o, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_mode_load", mode_load_o, 1'b0);
      chk("t5_wr_ready", wr_ready_o, 1'b0);
      chk("t5_wr_err", wr_err_o, 1'b0);
      chk("t5_resp_valid", resp_valid_o, 1'b0);
      chk("t5_resp_data", resp_data_o, 32'h0);
      chk("t5_req_ready", req_ready_o, 1'b1);
      wr_valid_i  = 1'b0;
      prog_mode_i = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      chk("t5_run_after", mode_load_o, 1'b0);
      req(32'h4, 1'b0, 32'hDEAD_BEEF);
      tick();
      chk("sb_drained_end", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
